// File: rtl/osd_pkg.sv
// Shared OSD definitions: command codes, default SPI ID byte, receiver state
// encoding and the byte-bus payload.
package osd_pkg;

  localparam logic [7:0] OSD_CMD_ENABLE = 8'd1;
  localparam logic [7:0] OSD_CMD_TILE   = 8'd2;
  localparam logic [7:0] OSD_ID_DEFAULT = 8'h5A;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } rx_state_e;

  typedef struct packed {
    logic       start;
    logic [7:0] data;
  } osd_byte_t;

endpackage

// File: rtl/osd_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, followed by a registered
// edge detector. level, rise and fall change on the same clock edge.
module osd_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[STAGES-2:0], din};
      level <= sync[STAGES-1];
      rise  <= sync[STAGES-1] & ~level;
      fall  <= ~sync[STAGES-1] & level;
    end
  end

endmodule

// File: rtl/osd_spi_rx.sv
// SPI mode-0 slave front end for the OSD: oversampled pins, byte assembly,
// ID/echo on MISO and a one-cycle strobe onto the OSD byte bus.
module osd_spi_rx
  import osd_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_BYTE     = OSD_ID_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_ss_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out,
  output logic       frame_active,
  output logic       frame_abort
);

  logic sck_rise, sck_fall, sck_level_unused;
  logic ss_level, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  osd_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .reset(reset), .din(spi_sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  osd_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .reset(reset), .din(spi_ss_n),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi changes on sck falling, so it is stable well around the detected rise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  rx_state_e state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] rx, rx_n, tx, tx_n;
  logic       first_flag, first_n;
  osd_byte_t  out_q, out_n;
  logic       strobe_n, abort_n;
  logic [7:0] rx_shifted;
  logic       byte_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= WAIT_IDLE;
      cnt             <= '0;
      rx              <= '0;
      tx              <= '0;
      first_flag      <= 1'b1;
      out_q           <= '0;
      data_out_strobe <= 1'b0;
      frame_abort     <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      rx              <= rx_n;
      tx              <= tx_n;
      first_flag      <= first_n;
      out_q           <= out_n;
      data_out_strobe <= strobe_n;
      frame_abort     <= abort_n;
    end
  end

  assign rx_shifted = {rx[6:0], mosi_s};
  assign byte_done  = sck_rise && (cnt == 3'd7);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rx_n     = rx;
    tx_n     = tx;
    first_n  = first_flag;
    out_n    = out_q;
    strobe_n = 1'b0;
    abort_n  = 1'b0;
    case (state)
      WAIT_IDLE: if (ss_level) state_n = IDLE;
      IDLE: begin
        if (ss_fall) begin
          state_n = SHIFT;
          first_n = 1'b1;
          cnt_n   = '0;
          tx_n    = ID_BYTE;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          rx_n  = rx_shifted;
          cnt_n = cnt + 3'd1;
          if (byte_done) begin
            strobe_n = 1'b1;
            out_n    = '{start: first_flag, data: rx_shifted};
            first_n  = 1'b0;
            tx_n     = rx_shifted;
          end
        // the fall right after a byte boundary would drop the echo's MSB
        end else if (sck_fall && cnt != 3'd0) begin
          tx_n = {tx[6:0], 1'b0};
        end
        if (ss_rise) begin
          state_n = IDLE;
          cnt_n   = '0;
          tx_n    = '0;
          abort_n = !byte_done && (cnt != 3'd0 || sck_rise);
        end
      end
      default: state_n = WAIT_IDLE;
    endcase
  end

  assign frame_active   = (state == SHIFT);
  assign spi_miso_oe    = frame_active;
  assign spi_miso       = frame_active & tx[7];
  assign data_out       = out_q.data;
  assign data_out_start = out_q.start;

endmodule
